// File: rtl/mul_result_assembler.sv
// Sequences one multiply through the 16x16 partial-product cell and assembles the low 32 product bits.
// Optional MUL_SPLIT_ADD_EN splits the upper-half add across an extra ADD state.
module mul_result_assembler #(
  parameter int DST_W           = 5,
  parameter int CLEAR_ON_ACCEPT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_valid,
  output logic             E_ready,
  input  logic [DST_W-1:0] E_dst,
  output logic             mul_cell_en,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  output logic             W_valid,
  input  logic             W_ready,
  output logic [31:0]      W_result,
  output logic [DST_W-1:0] W_dst,
  output logic             busy
);

`ifdef MUL_SPLIT_ADD_EN
  typedef enum logic [1:0] {S_IDLE, S_CELL, S_ADD, S_OUT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CELL, S_OUT} state_t;
`endif

  state_t           state_q, state_d;
  logic [31:0]      result_q, result_d;
  logic [DST_W-1:0] dst_q, dst_d;
  logic [DST_W-1:0] tag_q, tag_d;
  logic             accept;
  logic [15:0]      upper_sum;
`ifdef MUL_SPLIT_ADD_EN
  logic [15:0]      s_q, s_d;
  logic [31:0]      p1_q, p1_d;
`endif

  // Only the low halves of the cross products reach bits [31:16] of the result.
  logic unused_hi;
  assign unused_hi = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

  assign E_ready     = !reset && ((state_q == S_IDLE) || ((state_q == S_OUT) && W_ready));
  assign accept      = E_valid && E_ready;
  assign mul_cell_en = accept;
  assign W_valid     = (state_q == S_OUT);
  assign busy        = (state_q != S_IDLE);
  assign W_result    = result_q;
  assign W_dst       = dst_q;

`ifdef MUL_SPLIT_ADD_EN
  assign upper_sum = p1_q[31:16] + s_q;
`else
  assign upper_sum = M_mul_cell_p1[31:16] + M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    dst_d    = dst_q;
    tag_d    = tag_q;
`ifdef MUL_SPLIT_ADD_EN
    s_d      = s_q;
    p1_d     = p1_q;
`endif
    if (accept) begin
      tag_d = E_dst;
      if (CLEAR_ON_ACCEPT != 0) begin
        result_d = '0;
        dst_d    = '0;
      end
    end
    case (state_q)
      S_IDLE: if (accept) state_d = S_CELL;
      // Products are stable one cycle after the accept edge.
`ifdef MUL_SPLIT_ADD_EN
      S_CELL: begin
        s_d     = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
        p1_d    = M_mul_cell_p1;
        state_d = S_ADD;
      end
      S_ADD: begin
        result_d = {upper_sum, p1_q[15:0]};
        dst_d    = tag_q;
        state_d  = S_OUT;
      end
`else
      S_CELL: begin
        result_d = {upper_sum, M_mul_cell_p1[15:0]};
        dst_d    = tag_q;
        state_d  = S_OUT;
      end
`endif
      S_OUT: if (W_ready) state_d = accept ? S_CELL : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      dst_q    <= dst_d;
    end
  end

  // Tag and split-add operands only matter once state leaves IDLE.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
`ifdef MUL_SPLIT_ADD_EN
    s_q   <= s_d;
    p1_q  <= p1_d;
`endif
  end

endmodule

// File: tb/tb_mul_result_assembler.sv
// Directed bench for mul_result_assembler; the multiplier cell is modelled as a capture register on mul_cell_en.
module tb_mul_result_assembler;
`ifdef MUL_SPLIT_ADD_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 0;
  logic        reset = 1;
  logic        E_valid = 0;
  logic        E_ready;
  logic [4:0]  E_dst = '0;
  logic        mul_cell_en;
  logic [31:0] p1 = '0, p2 = '0, p3 = '0;
  logic        W_valid;
  logic        W_ready = 0;
  logic [31:0] W_result;
  logic [4:0]  W_dst;
  logic        busy;
  logic [31:0] src1 = '0, src2 = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (mul_cell_en) begin
      p1 <= src1[15:0] * src2[15:0];
      p2 <= src1[15:0] * src2[31:16];
      p3 <= src1[31:16] * src2[15:0];
    end

  mul_result_assembler #(.DST_W(5), .CLEAR_ON_ACCEPT(1)) dut (
    .clk(clk), .reset(reset), .E_valid(E_valid), .E_ready(E_ready), .E_dst(E_dst),
    .mul_cell_en(mul_cell_en), .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
    .W_valid(W_valid), .W_ready(W_ready), .W_result(W_result), .W_dst(W_dst), .busy(busy)
  );

  task automatic test_reset();
    @(negedge clk); E_valid = 1; #1;
    n_cmp++; if (E_ready !== 1'b0) begin n_fail++; $display("FAIL rst_e_ready got=%b want=0", E_ready); end
    n_cmp++; if (mul_cell_en !== 1'b0) begin n_fail++; $display("FAIL rst_cell_en got=%b want=0", mul_cell_en); end
    n_cmp++; if ({W_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_valid_busy got=%b want=00", {W_valid, busy}); end
    n_cmp++; if (W_result !== 32'h0) begin n_fail++; $display("FAIL rst_result got=%h want=0", W_result); end
    n_cmp++; if (W_dst !== 5'd0) begin n_fail++; $display("FAIL rst_dst got=%0d want=0", W_dst); end
    E_valid = 0; reset = 0; #1;
    n_cmp++; if (E_ready !== 1'b1) begin n_fail++; $display("FAIL idle_e_ready got=%b want=1", E_ready); end
  endtask

  task automatic run_op(input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] dst,
                        input logic [31:0] exp_res, input string name);
    @(negedge clk);
    src1 = s1; src2 = s2; E_dst = dst; E_valid = 1; W_ready = 1; #1;
    n_cmp++; if ({E_ready, mul_cell_en} !== 2'b11) begin n_fail++; $display("FAIL %s_accept got=%b want=11", name, {E_ready, mul_cell_en}); end
    @(posedge clk); #1; E_valid = 0;
    for (int k = 1; k < LAT; k++) begin
      n_cmp++;
      if ({W_valid, E_ready, busy, mul_cell_en} !== 4'b0010) begin
        n_fail++; $display("FAIL %s_inflight%0d got=%b want=0010", name, k, {W_valid, E_ready, busy, mul_cell_en});
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (W_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got=%b want=1", name, W_valid); end
    n_cmp++; if (W_result !== exp_res) begin n_fail++; $display("FAIL %s_result got=%h want=%h", name, W_result, exp_res); end
    n_cmp++; if (W_dst !== dst) begin n_fail++; $display("FAIL %s_dst got=%0d want=%0d", name, W_dst, dst); end
    @(posedge clk); #1;
    n_cmp++; if ({W_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL %s_drain got=%b want=00", name, {W_valid, busy}); end
  endtask

  task automatic test_arith();
    run_op(32'd3, 32'd5, 5'd7, 32'h0000000F, "small");
    run_op(32'h00010003, 32'h00020005, 5'd12, 32'h000B000F, "cross");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h00000001, "allones");
    run_op(32'h00010000, 32'h00010000, 5'd1, 32'h00000000, "hiwrap");
    run_op(32'h0003FFFF, 32'h00050002, 5'd9, 32'h0002FFFE, "carry");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    src1 = 32'h00010003; src2 = 32'h00020005; E_dst = 5'd4; E_valid = 1; W_ready = 1;
    @(posedge clk); #1;
    E_valid = 1; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; E_dst = 5'd21;
    for (int k = 1; k < LAT; k++) begin @(posedge clk); #1; end
    W_ready = 0; #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({W_valid, E_ready, mul_cell_en} !== 3'b100) begin
        n_fail++; $display("FAIL stall%0d_ctrl got=%b want=100", k, {W_valid, E_ready, mul_cell_en});
      end
      n_cmp++;
      if ({W_result, W_dst} !== {32'h000B000F, 5'd4}) begin
        n_fail++; $display("FAIL stall%0d_data got=%h/%0d want=000b000f/4", k, W_result, W_dst);
      end
      @(posedge clk); #1;
    end
    W_ready = 1; #1;
    n_cmp++; if ({E_ready, mul_cell_en} !== 2'b11) begin n_fail++; $display("FAIL b2b_accept got=%b want=11", {E_ready, mul_cell_en}); end
    @(posedge clk); #1; E_valid = 0;
    n_cmp++; if ({W_valid, busy, W_result} !== {2'b01, 32'h0}) begin
      n_fail++; $display("FAIL b2b_cleared got=%b/%h want=01/00000000", {W_valid, busy}, W_result);
    end
    for (int k = 1; k < LAT; k++) begin @(posedge clk); #1; end
    n_cmp++; if ({W_valid, W_result, W_dst} !== {1'b1, 32'h00000001, 5'd21}) begin
      n_fail++; $display("FAIL b2b_second got=%b/%h/%0d want=1/00000001/21", W_valid, W_result, W_dst);
    end
    @(posedge clk); #1;
    n_cmp++; if (W_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b want=0", W_valid); end
  endtask

  task automatic test_reset_in_flight();
    @(negedge clk);
    src1 = 32'd3; src2 = 32'd5; E_dst = 5'd7; E_valid = 1; W_ready = 1;
    @(posedge clk); #1; E_valid = 0; reset = 1;
    @(posedge clk); #1; reset = 0;
    n_cmp++; if ({W_valid, busy, W_result} !== {2'b00, 32'h0}) begin
      n_fail++; $display("FAIL midrst_state got=%b/%h want=00/00000000", {W_valid, busy}, W_result);
    end
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (W_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost%0d got=%b want=0", k, W_valid); end
    end
    run_op(32'h00010003, 32'h00020005, 5'd2, 32'h000B000F, "postrst");
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
